multi_freq_div: RTL and testbench
=================================

// Module: multi_freq_div
// PURPOSE
//  Multi-channel programmable frequency divider. Each channel divides clk by a
//  runtime-loadable integer divisor and emits a one-cycle tick strobe plus a
//  near-50% square wave. Feeds timers, display refresh and sample-rate enables
//  from the 50 MHz board clock. Default divisor gives 256 Hz from 50 MHz.
// PARAMETERS
//  NUM_CH       4        number of independent divider channels (1..16)
//  CH_W         2        width of channel select, >= clog2(NUM_CH), min 1
//  WIDTH        32       divisor / counter width in bits
//  DEFAULT_DIV  195312   divisor loaded into every channel on reset (!= 0)
// PORTS
//  clk         in   1          system clock
//  reset       in   1          reset, asynchronous, active-high
//  enable      in   1          global count enable
//  sync        in   1          restart all channels phase-aligned
//  load_valid  in   1          divisor load request
//  load_ready  out  1          channel addressed by load_ch can accept a load
//  load_ch     in   CH_W       target channel of load
//  load_div    in   WIDTH      new divisor, unsigned
//  tick_out    out  NUM_CH     per-channel one-cycle strobe, once per period
//  sq_out      out  NUM_CH     per-channel square wave
//  err         out  1          sticky: illegal load seen (div==0 or ch>=NUM_CH)
// BEHAVIOUR
//  Reset: count[i]=0, div[i]=DEFAULT_DIV, pending[i]=0, tick_out=0, sq_out=0,
//   err=0. Async assert; all state cleared regardless of in-flight loads.
//  Per channel, each clk edge with enable=1 and sync=0:
//   count <= (count==div-1) ? 0 : count+1 (WIDTH-bit, no overflow past div-1)
//   tick_out[i] <= (count==div-1); sq_out[i] <= (count < (div+1)>>1)
//   Outputs registered: one-cycle latency from counter state. Period = div clks.
//   div=1: tick_out constantly 1, sq_out constantly 1. div=2: exact 50%.
//   Odd div: high for (div+1)/2 clks, low for (div-1)/2.
//  enable=0: count and sq_out hold, tick_out forced 0 next edge. Loads and
//   sync still processed.
//  Load handshake: accepted on edge where load_valid && load_ready.
//   load_ready = ~pending[load_ch] (combinational; 0 if load_ch>=NUM_CH).
//   Accepted legal load: stored in shadow reg, pending[ch]=1. Applied
//   glitch-free at that channel's terminal count (count==div-1, enabled):
//   div<=shadow, count<=0, pending<=0. Current period always completes.
//   load_div==0 or load_ch>=NUM_CH: err<=1 (sticky until reset), divisor
//   unchanged, no pending set. load_valid held low-ready is not an accept.
//  sync=1 (takes priority over enable=0): all count<=0, tick_out<=0,
//   sq_out<=1; every pending shadow applied immediately, pending cleared.
//   Load accepted in same cycle as sync: applied immediately too.
//  Terminal count coincident with load accept on same channel: old shadow
//   state irrelevant (pending was 0); new value becomes pending, applied at
//   the NEXT terminal count.
//  Channels fully independent; no cross-channel ordering except via sync.
// TESTING
//  1. Reset, DEFAULT_DIV=8 in bench, enable=1 -> tick_out[0] pulses every 8
//     clks, first after 8 edges; sq_out 4 high / 4 low.
//  2. Load ch1 div=3 mid-period -> old period finishes, then tick every 3,
//     sq 2 high / 1 low; load_ready for ch1 low until applied.
//  3. Load div=0 and load_ch=NUM_CH -> err=1 sticky, divisors unchanged,
//     no pending; reset clears err.
//  4. Channels at div 4,6 free-running, pulse sync -> next edge all counts 0,
//     sq_out all 1, tick_out[0]/[1] first coincide 12 clks later.
//  5. enable low for 5 clks mid-period -> tick_out 0, count frozen; period
//     resumes with exactly remaining cycles; div=1 channel ticks every clk.
//  6. Assert reset asynchronously with pending load -> outputs 0 immediately,
//     divisor back to DEFAULT_DIV, pending discarded.

Source files
------------

// File: rtl/multi_freq_div_if.sv
// multi_freq_div_if: divisor-load handshake between a controller and the divider
interface multi_freq_div_if #(
  parameter int CH_W  = 2,
  parameter int WIDTH = 32
);
  logic             load_valid;
  logic             load_ready;
  logic [CH_W-1:0]  load_ch;
  logic [WIDTH-1:0] load_div;
  modport master (output load_valid, load_ch, load_div, input load_ready);
  modport slave  (input load_valid, load_ch, load_div, output load_ready);
endinterface

// File: rtl/multi_freq_div.sv
// multi_freq_div: multi-channel programmable clock divider with shadowed, glitch-free divisor loads
module multi_freq_div #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 195312
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync,
  multi_freq_div_if.slave   ld,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] sq_out,
  output logic              err
);
  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);
  logic              ch_ok;
  logic              accept;
  logic [NUM_CH-1:0] pending;
  // A load is only taken by an existing channel that has no divisor waiting to be applied
  always_comb begin
    ch_ok         = {1'b0, ld.load_ch} < NCH;
    ld.load_ready = ch_ok && !pending[ld.load_ch];
    accept        = ld.load_valid && ld.load_ready && ld.load_div != '0;
  end
  // Any request naming a missing channel or a zero divisor latches the error until reset
  always_ff @(posedge clk or posedge reset)
    if (reset) err <= 1'b0;
    else if (ld.load_valid && (!ch_ok || ld.load_div == '0)) err <= 1'b1;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH:0]   half;
    logic             term;
    logic             wr;
    logic             tick;
    logic             sq;
    logic             pend;
    // Terminal-count detect, load targeting this channel, and high-phase length ceil(div/2)
    always_comb begin
      term = count == div - WIDTH'(1);
      wr   = accept && ld.load_ch == CH_W'(g);
      half = ({1'b0, div} + (WIDTH+1)'(1)) >> 1;
    end
    // Counter, shadow divisor and registered outputs; new divisors only take effect at a period boundary or sync
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        count  <= '0;
        div    <= WIDTH'(DEFAULT_DIV);
        shadow <= '0;
        pend   <= 1'b0;
        tick   <= 1'b0;
        sq     <= 1'b0;
      end else if (sync) begin
        count <= '0;
        div   <= wr ? ld.load_div : pend ? shadow : div;
        pend  <= 1'b0;
        tick  <= 1'b0;
        sq    <= 1'b1;
      end else begin
        if (enable) begin
          tick  <= term;
          sq    <= {1'b0, count} < half;
          count <= term ? '0 : count + WIDTH'(1);
          if (term && pend) begin
            div  <= shadow;
            pend <= 1'b0;
          end
        end else tick <= 1'b0;
        if (wr) begin
          shadow <= ld.load_div;
          pend   <= 1'b1;
        end
      end
    assign tick_out[g] = tick;
    assign sq_out[g]   = sq;
    assign pending[g]  = pend;
  end
endmodule

// File: tb/tb_multi_freq_div.sv
// tb_multi_freq_div: randomized scoreboard bench comparing the divider against a period/phase reference model
module tb_multi_freq_div;
  localparam int NCH = 3;
  localparam int CW  = 2;
  localparam int W   = 8;
  localparam int DEF = 8;
  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic           err;
  } out_t;
  logic           clk = 0;
  logic           reset = 1;
  logic           enable = 0;
  logic           sync = 0;
  logic [NCH-1:0] tick_out;
  logic [NCH-1:0] sq_out;
  logic           err;
  multi_freq_div_if #(.CH_W(CW), .WIDTH(W)) bus();
  multi_freq_div #(.NUM_CH(NCH), .CH_W(CW), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .ld(bus),
    .tick_out(tick_out), .sq_out(sq_out), .err(err)
  );
  out_t out_q[$];
  bit   rdy_q[$];
  int   passed = 0;
  int   total = 0;
  int   md[NCH];
  int   mleft[NCH];
  int   mshv[NCH];
  bit   mpend[NCH];
  bit   msq[NCH];
  bit   merr;
  // 100 MHz bench clock
  always #5 clk = ~clk;
  function automatic void chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      md[i] = DEF;
      mleft[i] = DEF;
      mshv[i] = 0;
      mpend[i] = 0;
      msq[i] = 0;
    end
    merr = 0;
  endfunction
  // Reference: each channel tracks cycles left in its period; ticks on the last one, high for the first ceil(div/2)
  function automatic void model(bit en, bit sy, bit lv, int lch, int ldiv, output bit rdy, output out_t o);
    bit acc;
    o = '0;
    rdy = (lch < NCH) ? !mpend[lch] : 1'b0;
    acc = lv && rdy && ldiv != 0;
    if (lv && (lch >= NCH || ldiv == 0)) merr = 1;
    o.err = merr;
    for (int i = 0; i < NCH; i++) begin
      if (sy) begin
        if (acc && lch == i) md[i] = ldiv;
        else if (mpend[i]) md[i] = mshv[i];
        mpend[i] = 0;
        mleft[i] = md[i];
        msq[i] = 1;
      end else begin
        if (en) begin
          o.tick[i] = (mleft[i] == 1);
          msq[i] = (md[i] - mleft[i]) < (md[i] + 1) / 2;
          if (mleft[i] == 1) begin
            if (mpend[i]) begin
              md[i] = mshv[i];
              mpend[i] = 0;
            end
            mleft[i] = md[i];
          end else mleft[i]--;
        end
        if (acc && lch == i) begin
          mshv[i] = ldiv;
          mpend[i] = 1;
        end
      end
      o.sq[i] = msq[i];
    end
  endfunction
  task automatic step(bit en, bit sy, bit lv, int lch, int ldiv);
    bit   r;
    out_t o;
    enable = en;
    sync = sy;
    bus.load_valid = lv;
    bus.load_ch = 2'(lch);
    bus.load_div = 8'(ldiv);
    model(en, sy, lv, lch, ldiv, r, o);
    rdy_q.push_back(r);
    out_q.push_back(o);
    @(posedge clk);
    #2;
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 1);
  endtask
  // Handshake monitor: load_ready is stable mid-cycle for the request about to be sampled
  always @(negedge clk)
    if (rdy_q.size() != 0) chk("load_ready", int'(bus.load_ready), int'(rdy_q.pop_front()));
  // Output monitor: registered outputs compared just after each edge
  always begin
    out_t e;
    @(posedge clk);
    #1;
    if (out_q.size() != 0) begin
      e = out_q.pop_front();
      chk("tick_out", int'(tick_out), int'(e.tick));
      chk("sq_out", int'(sq_out), int'(e.sq));
      chk("err", int'(err), int'(e.err));
    end
  end
  // Hang guard
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    bus.load_valid = 0;
    bus.load_ch = 0;
    bus.load_div = 0;
    model_reset();
    #12;
    chk("reset_tick", int'(tick_out), 0);
    chk("reset_sq", int'(sq_out), 0);
    chk("reset_err", int'(err), 0);
    @(posedge clk);
    #2;
    reset = 0;
    run(20);
    step(1, 0, 1, 1, 3);
    run(3);
    step(1, 0, 1, 1, 5);
    run(20);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 3, 5);
    run(10);
    step(1, 0, 1, 2, 5);
    #2;
    reset = 1;
    #1;
    chk("async_tick", int'(tick_out), 0);
    chk("async_sq", int'(sq_out), 0);
    chk("async_err", int'(err), 0);
    bus.load_valid = 0;
    bus.load_ch = 2;
    #1;
    chk("async_ready", int'(bus.load_ready), 1);
    @(posedge clk);
    #2;
    reset = 0;
    model_reset();
    run(12);
    step(1, 0, 1, 0, 4);
    step(1, 0, 1, 1, 6);
    run(3);
    step(1, 1, 0, 0, 1);
    run(26);
    run(2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    run(10);
    step(1, 0, 1, 2, 1);
    run(12);
    step(1, 1, 1, 2, 7);
    step(0, 1, 0, 0, 1);
    run(10);
    for (int i = 0; i < 400; i++)
      step($urandom_range(99) < 85, $urandom_range(99) < 3, $urandom_range(99) < 30,
           $urandom_range(NCH - 1), $urandom_range(9, 1));
    chk("queue_drain", out_q.size() + rdy_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
